// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, control codes, state and instruction-class encodings for mc_ctrl
package mc_ctrl_pkg;
  localparam logic [6:0] OP_ADDU = 7'b1000011;
  localparam logic [6:0] OP_SUBU = 7'b1000111;
  localparam logic [6:0] OP_ORI  = 7'b0011010;
  localparam logic [6:0] OP_LW   = 7'b1000110;
  localparam logic [6:0] OP_SW   = 7'b1010110;
  localparam logic [6:0] OP_BEQ  = 7'b0001000;
  localparam logic [6:0] OP_J    = 7'b0000100;
  localparam logic [1:0] NPC_NML = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd4;
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_DECD, S_EXE, S_MEM, S_WB, S_ERR} state_e;
  typedef enum logic [2:0] {C_ILL, C_ALU, C_LW, C_SW, C_BEQ, C_J} cls_e;
endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: opcode -> instruction class and state-independent datapath controls
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 4
) (
  input  logic [OP_W-1:0]    i_op,
  output cls_e               o_cls,
  output logic               o_ext,
  output logic               o_rwsel,
  output logic               o_memtoreg,
  output logic [ALUOP_W-1:0] o_aluop
);
  logic w_addu, w_subu, w_ori, w_lw, w_sw, w_beq, w_j;
  assign w_addu = i_op == OP_W'(OP_ADDU);
  assign w_subu = i_op == OP_W'(OP_SUBU);
  assign w_ori  = i_op == OP_W'(OP_ORI);
  assign w_lw   = i_op == OP_W'(OP_LW);
  assign w_sw   = i_op == OP_W'(OP_SW);
  assign w_beq  = i_op == OP_W'(OP_BEQ);
  assign w_j    = i_op == OP_W'(OP_J);
  // classify the opcode and derive the controls that do not depend on the FSM state
  always_comb begin
    o_cls      = (w_addu | w_subu | w_ori) ? C_ALU :
                 w_lw ? C_LW : w_sw ? C_SW : w_beq ? C_BEQ : w_j ? C_J : C_ILL;
    o_ext      = w_ori | w_lw | w_sw | w_beq;
    o_rwsel    = w_addu | w_subu;
    o_memtoreg = ~w_lw;
    o_aluop    = (w_addu | w_lw | w_sw) ? ALUOP_W'(ALU_ADD) :
                 (w_subu | w_beq) ? ALUOP_W'(ALU_SUB) :
                 w_ori ? ALUOP_W'(ALU_OR) : ALUOP_W'(ALU_NOP);
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS32 control FSM with memory wait timeout and trap; MC_CTRL_PERF_EN adds perf counters
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 7,
  parameter int ALUOP_W = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [OP_W-1:0]    decdOp,
  input  logic               zero,
  input  logic               mem_rdy,
  output logic               PCWr,
  output logic               IRWr,
  output logic               GPRWr,
  output logic               ExtOp,
  output logic               RWSel,
  output logic               BSel,
  output logic               DMWr,
  output logic               DMRd,
  output logic               MemToReg,
  output logic [1:0]         nPCOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               busy,
  output logic               err,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [CNT_W-1:0]   cyc_cnt
);
  localparam int WW = $clog2(TIMEOUT + 2);
  state_e              r_state, w_next;
  logic [OP_W-1:0]     r_op, w_op;
  logic [WW-1:0]       r_wait;
  cls_e                w_cls;
  logic                w_ext, w_rwsel, w_m2r, w_tmo;
  logic [ALUOP_W-1:0]  w_alu;
  // the opcode is only latched at the end of DECD, so DECD itself decodes the live input
  assign w_op  = (r_state == S_DECD) ? decdOp : r_op;
  assign w_tmo = (TIMEOUT != 0) && (32'(r_wait) + 32'd1 == 32'(TIMEOUT));
  mc_ctrl_dec #(.OP_W(OP_W), .ALUOP_W(ALUOP_W)) u_dec (
    .i_op      (w_op),
    .o_cls     (w_cls),
    .o_ext     (w_ext),
    .o_rwsel   (w_rwsel),
    .o_memtoreg(w_m2r),
    .o_aluop   (w_alu)
  );
  // state, latched opcode and MEM wait counter
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_INIT;
      r_op    <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECD) r_op <= decdOp;
      r_wait  <= (r_state == S_MEM && w_next == S_MEM) ? r_wait + 1'b1 : '0;
    end
  end
  // next state; memory completion takes priority over the timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  w_next = S_FETCH;
      S_FETCH: w_next = S_DECD;
      S_DECD:  w_next = (w_cls == C_J) ? S_FETCH : (w_cls == C_ILL) ? S_ERR : S_EXE;
      S_EXE:   w_next = (w_cls == C_BEQ) ? S_FETCH : (w_cls == C_LW || w_cls == C_SW) ? S_MEM : S_WB;
      S_MEM:   w_next = mem_rdy ? ((w_cls == C_LW) ? S_WB : S_FETCH) : w_tmo ? S_ERR : S_MEM;
      S_WB:    w_next = S_FETCH;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_INIT;
    endcase
  end
  // datapath controls gated by state; PCWr marks the final cycle of each retired instruction
  always_comb begin
    IRWr     = r_state == S_FETCH;
    PCWr     = (r_state == S_DECD && w_cls == C_J) || (r_state == S_EXE && w_cls == C_BEQ) ||
               (r_state == S_MEM && w_cls == C_SW && mem_rdy) || r_state == S_WB;
    GPRWr    = r_state == S_WB;
    ExtOp    = r_state == S_EXE && w_ext;
    BSel     = r_state == S_EXE && w_ext;
    RWSel    = r_state == S_WB && w_rwsel;
    MemToReg = r_state == S_WB && w_m2r;
    DMRd     = r_state == S_MEM && w_cls == C_LW;
    DMWr     = r_state == S_MEM && w_cls == C_SW;
    nPCOp    = (r_state == S_DECD && w_cls == C_J) ? NPC_J :
               (r_state == S_EXE && w_cls == C_BEQ && zero) ? NPC_BEQ : NPC_NML;
    ALUOp    = (r_state == S_EXE) ? w_alu : ALUOP_W'(ALU_NOP);
    busy     = r_state != S_INIT && r_state != S_ERR;
    err      = r_state == S_ERR;
  end
`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] r_instr, r_cyc;
  // busy-cycle and retirement counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (clr) begin
      r_instr <= '0;
      r_cyc   <= '0;
    end else begin
      r_instr <= r_instr + CNT_W'(PCWr);
      r_cyc   <= r_cyc + CNT_W'(busy);
    end
  end
  assign instr_cnt = r_instr;
  assign cyc_cnt   = r_cyc;
`else
  assign instr_cnt = '0;
  assign cyc_cnt   = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven, hand-written and random instruction sequences checked per cycle against a class-level model
module tb_mc_ctrl;
  localparam int TO = 15;
  localparam logic [6:0] ADDU = 7'b1000011, SUBU = 7'b1000111, ORI = 7'b0011010,
                         LW = 7'b1000110, SW = 7'b1010110, BEQ = 7'b0001000, JJ = 7'b0000100;
  logic clk = 0, clr = 1, zero = 0, mem_rdy = 0;
  logic [6:0] decdOp = '0;
  logic PCWr, IRWr, GPRWr, ExtOp, RWSel, BSel, DMWr, DMRd, MemToReg, busy, err;
  logic [1:0] nPCOp;
  logic [3:0] ALUOp;
  logic [31:0] instr_cnt, cyc_cnt;
  int n_run = 0, n_fail = 0, e_instr = 0, e_cyc = 0;
  logic [16:0] w_out;
  mc_ctrl #(.OP_W(7), .ALUOP_W(4), .TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .clr(clr), .decdOp(decdOp), .zero(zero), .mem_rdy(mem_rdy),
    .PCWr(PCWr), .IRWr(IRWr), .GPRWr(GPRWr), .ExtOp(ExtOp), .RWSel(RWSel), .BSel(BSel),
    .DMWr(DMWr), .DMRd(DMRd), .MemToReg(MemToReg), .nPCOp(nPCOp), .ALUOp(ALUOp),
    .busy(busy), .err(err), .instr_cnt(instr_cnt), .cyc_cnt(cyc_cnt)
  );
  assign w_out = {PCWr, IRWr, GPRWr, ExtOp, RWSel, BSel, DMWr, DMRd, MemToReg, nPCOp, ALUOp, busy, err};
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  typedef struct {logic [6:0] op; bit z; int w; int lat; string nm;} vec_t;
  vec_t tv[14];
  logic [6:0] ops[7];

  function automatic logic [16:0] pk(input bit pc, ir, gpr, ext, rw, bs, dw, dr, m2r,
                                     input logic [1:0] np, input logic [3:0] alu, input bit bsy, er);
    return {pc, ir, gpr, ext, rw, bs, dw, dr, m2r, np, alu, bsy, er};
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op == ADDU || op == SUBU || op == ORI || op == LW || op == SW || op == BEQ || op == JJ;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
`ifdef MC_CTRL_PERF_EN
    chk({nm, ".instr_cnt"}, 64'(instr_cnt), 64'(e_instr));
    chk({nm, ".cyc_cnt"}, 64'(cyc_cnt), 64'(e_cyc));
`else
    chk({nm, ".cnt_tied"}, {instr_cnt, cyc_cnt}, 64'd0);
`endif
  endtask

  task automatic cyc(input logic [6:0] op, input bit z, input bit r);
    @(negedge clk);
    decdOp = op;
    zero = z;
    mem_rdy = r;
    #1;
  endtask

  task automatic rst();
    @(negedge clk);
    clr = 1;
    mem_rdy = 0;
    @(negedge clk);
    #1 chk("rst.c0", w_out, 0);
    @(negedge clk);
    #1 chk("rst.c1", w_out, 0);
    e_instr = 0;
    e_cyc = 0;
    chk_cnt("rst");
    clr = 0;
    #1 chk("rst.init", w_out, 0);
  endtask

  task automatic run(input logic [6:0] op, input bit z, input int waits, input int lat_exp, input string nm);
    logic [16:0] q[$];
    bit rq[$];
    int lat;
    bit isr, isi, lw, sw, bq, jj, imm;
    logic [3:0] alu;
    logic [16:0] perr;
    isr = op == ADDU || op == SUBU;
    isi = op == ORI;
    lw = op == LW;
    sw = op == SW;
    bq = op == BEQ;
    jj = op == JJ;
    imm = isi || lw || sw || bq;
    alu = (op == ADDU || lw || sw) ? 4'd1 : (op == SUBU || bq) ? 4'd2 : isi ? 4'd4 : 4'd0;
    perr = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 0, 1);
    q.push_back(pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 1, 0)); rq.push_back(1'($urandom));
    q.push_back(pk(jj, 0, 0, 0, 0, 0, 0, 0, 0, jj ? 2'd2 : 2'd0, 4'd0, 1, 0)); rq.push_back(1'($urandom));
    if (!legal(op)) begin
      repeat (3) begin q.push_back(perr); rq.push_back(1'($urandom)); end
    end else if (!jj) begin
      q.push_back(pk(bq, 0, 0, imm, 0, imm, 0, 0, 0, (bq && z) ? 2'd1 : 2'd0, alu, 1, 0));
      rq.push_back(1'($urandom));
      if (lw || sw) begin
        for (int i = 0; i < waits && !(TO != 0 && i >= TO); i++) begin
          q.push_back(pk(0, 0, 0, 0, 0, 0, sw, lw, 0, 2'd0, 4'd0, 1, 0)); rq.push_back(0);
        end
        if (TO != 0 && waits >= TO) begin
          repeat (3) begin q.push_back(perr); rq.push_back(1'($urandom)); end
        end else begin
          q.push_back(pk(sw, 0, 0, 0, 0, 0, sw, lw, 0, 2'd0, 4'd0, 1, 0)); rq.push_back(1);
          if (lw) begin q.push_back(pk(1, 0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 4'd0, 1, 0)); rq.push_back(1'($urandom)); end
        end
      end else if (!bq) begin
        q.push_back(pk(1, 0, 1, 0, isr, 0, 0, 0, 1, 2'd0, 4'd0, 1, 0)); rq.push_back(1'($urandom));
      end
    end
    lat = 0;
    foreach (q[i]) begin
      cyc((i == 1) ? op : 7'($urandom), (i == 2) ? z : 1'($urandom), rq[i]);
      if (i == 0) chk_cnt(nm);
      chk($sformatf("%s.c%0d", nm, i), w_out, q[i]);
      if (PCWr && lat == 0) lat = i + 1;
      e_instr += int'(q[i][16]);
      e_cyc += int'(q[i][1]);
    end
    chk({nm, ".lat"}, 64'(lat), 64'(lat_exp));
    if (lat_exp == 0) rst();
  endtask

  initial begin
    int k, w, lat;
    logic [6:0] op;
    tv[0]  = '{ADDU, 0, 0, 4, "addu"};
    tv[1]  = '{ORI, 0, 0, 4, "ori"};
    tv[2]  = '{SUBU, 1, 0, 4, "subu"};
    tv[3]  = '{BEQ, 1, 0, 3, "beq_taken"};
    tv[4]  = '{BEQ, 0, 0, 3, "beq_not"};
    tv[5]  = '{JJ, 0, 0, 2, "j"};
    tv[6]  = '{LW, 0, 3, 8, "lw_w3"};
    tv[7]  = '{SW, 0, 0, 4, "sw_w0"};
    tv[8]  = '{LW, 0, 0, 5, "lw_w0"};
    tv[9]  = '{SW, 0, 14, 18, "sw_w14"};
    tv[10] = '{LW, 1, 14, 19, "lw_w14"};
    tv[11] = '{SW, 0, 15, 0, "sw_timeout"};
    tv[12] = '{7'b1111111, 0, 0, 0, "illegal"};
    tv[13] = '{ADDU, 1, 0, 4, "addu_after"};
    ops = '{ADDU, SUBU, ORI, LW, SW, BEQ, JJ};
    rst();
    foreach (tv[i]) run(tv[i].op, tv[i].z, tv[i].w, tv[i].lat, tv[i].nm);
    // clr in the middle of a MEM wait aborts the load without a PC write
    cyc(7'($urandom), 0, 0);
    cyc(LW, 0, 0);
    cyc(7'($urandom), 0, 0);
    cyc(7'($urandom), 0, 0);
    cyc(7'($urandom), 0, 0);
    chk("abort.mem", w_out, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 4'd0, 1, 0));
    @(negedge clk);
    clr = 1;
    #1 chk("abort.clr_cycle", w_out, pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 4'd0, 1, 0));
    @(negedge clk);
    clr = 0;
    #1 chk("abort.init", w_out, 0);
    e_instr = 0;
    e_cyc = 0;
    run(ADDU, 0, 0, 4, "abort.recover");
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 6);
      op = ops[k];
      w = $urandom_range(0, 4);
      lat = (op == JJ) ? 2 : (op == BEQ) ? 3 : (op == SW) ? 4 + w : (op == LW) ? 5 + w : 4;
      run(op, 1'($urandom), w, lat, $sformatf("rnd%0d", n));
    end
    do op = 7'($urandom); while (legal(op));
    run(op, 0, 0, 0, "rnd_illegal");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Parametrised multicycle control unit for the MIPS32 datapath.
- Sequences each instruction through a per-class variable-length FSM: FETCH, DECD, EXE, MEM, WB.
- Adds a memory ready/wait handshake with a timeout, illegal-opcode trapping, and a single PC write at retirement.
- Sits between the instruction decoder (decdOp) and the PC, IR, GPR, ALU and DM write/select controls.

Parameters:
- OP_W, 7: width of decdOp.
- ALUOP_W, 4: width of ALUOp.
- TIMEOUT, 15: maximum MEM wait cycles before trap; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, posedge.
- clr  in  1  synchronous active-high reset.
- decdOp  in  OP_W  decoded opcode; valid during DECD.
- zero  in  1  ALU zero flag; sampled in EXE.
- mem_rdy  in  1  data memory completes the access this cycle.
- PCWr, IRWr, GPRWr, ExtOp, RWSel, BSel, DMWr, DMRd, MemToReg  out  1  datapath controls.
- nPCOp  out  2  next-PC select: nml=00, beq=01, j=10.
- ALUOp  out  ALUOP_W  ALU operation: nop=0, add=1, sub=2, or=4.
- busy  out  1  high in every state except INIT and ERR.
- err  out  1  sticky trap flag.
- instr_cnt, cyc_cnt  out  CNT_W  performance counters (see Optional Feature).

Behaviour:
- Reset and timing:
  - clr is sampled on posedge clk only.
  - When clr is high: state=INIT, op_q=0, wait counter=0, err=0.
  - All outputs decode combinationally from state and op_q, so reset drives every enable to 0, ALUOp=nop, nPCOp=nml, busy=0.
  - clr asserted in any state, including mid-MEM wait, aborts the instruction with no PC write.
- States: INIT, FETCH, DECD, EXE, MEM, WB, ERR.
- Transitions:
  - INIT -> FETCH unconditionally.
  - FETCH: IRWr=1 -> DECD.
  - DECD: op_q<=decdOp.
    - j: PCWr=1, nPCOp=j -> FETCH.
    - addu, subu, ori, lw, sw, beq -> EXE.
    - any other opcode -> ERR.
  - EXE: ALUOp is add for addu/lw/sw, sub for subu/beq, or for ori. BSel=ExtOp=1 for ori/lw/sw/beq.
    - beq: PCWr=1, nPCOp = zero ? beq : nml -> FETCH.
    - lw, sw -> MEM.
    - others -> WB.
  - MEM: lw holds DMRd=1; sw holds DMWr=1. Both hold until mem_rdy.
    - mem_rdy=1: lw -> WB; sw retires with PCWr=1, nPCOp=nml -> FETCH.
    - mem_rdy=0: wait counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT -> ERR. The counter clears on MEM exit.
    - mem_rdy=1 in the same cycle the counter reaches TIMEOUT: completion wins.
  - WB: GPRWr=1, PCWr=1, nPCOp=nml. RWSel=1 for addu/subu. MemToReg=0 for lw, 1 otherwise -> FETCH.
  - ERR: err=1, all enables 0. Stays in ERR until clr.
- Latency: j=2 cycles, beq=3, addu/subu/ori=4, sw=4+waits, lw=5+waits.
- Retirement: PCWr is asserted exactly once per retired instruction, in its final cycle.
- DMWr and DMRd are never high together. GPRWr and DMWr are never high together.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined:
  - cyc_cnt increments every cycle that busy=1.
  - instr_cnt increments every cycle that PCWr=1.
  - Both wrap modulo 2^CNT_W and both clear on clr.
- Undefined: the counter logic is removed, and instr_cnt and cyc_cnt are tied to 0.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants: addu 1000011, subu 1000111, ori 0011010, lw 1000110, sw 1010110, beq 0001000, j 0000100;
  - the nPCOp and ALUOp codes;
  - the state encoding (3 bits).
- Sub-module mc_ctrl_dec: combinational op_q -> instruction class plus static controls (ExtOp, BSel, RWSel, MemToReg, ALUOp). The FSM in mc_ctrl gates these by state.

Test Plan:
- Reset: clr=1 for 2 cycles, then 0 -> INIT then FETCH on the next edge; all enables 0 while clr=1; err=0.
- addu then ori: each takes 4 cycles. WB shows GPRWr=1, PCWr=1; RWSel=1 for addu and 0 for ori; ALUOp=1 then 4; instr_cnt=2 (PERF_EN).
- beq: zero=1 -> EXE shows PCWr=1, nPCOp=01, total 3 cycles. Repeat with zero=0 -> nPCOp=00.
- lw with mem_rdy low for 3 cycles: DMRd=1 for 4 MEM cycles, then WB with MemToReg=0. Total 8 cycles.
- sw with mem_rdy never high, TIMEOUT=15: ERR after 15 wait cycles, err=1, DMWr drops. clr recovers to INIT.
- Illegal opcode 7'b1111111 at DECD -> ERR next cycle; no PCWr or GPRWr ever asserted.
